ascon_arbiter: RTL and testbench

ASCON_ARBITER -- requirements
Module: ascon_arbiter

---
 rtl/ascon_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ascon_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_arbiter.sv
// Two-client arbiter for one Ascon core; grant 1 cycle after request, data paths combinational.
// Backpressure: a waiting client sees all ready/valid at 0 until granted; core handshakes pass straight through.
// Build option: define ASCON_ARB_RR_EN for round-robin, otherwise client 0 has fixed priority.
module ascon_arbiter #(
    parameter int CCW  = 32,
    parameter int CCSW = 32
) (
    input  logic            clk,
    input  logic            rst,
    // client 0
    input  logic [CCSW-1:0] c0_key,
    input  logic            c0_key_valid,
    output logic            c0_key_ready,
    input  logic [CCW-1:0]  c0_bdi,
    input  logic            c0_bdi_valid,
    output logic            c0_bdi_ready,
    input  logic [3:0]      c0_bdi_type,
    input  logic            c0_bdi_eot,
    input  logic            c0_bdi_eoi,
    input  logic            c0_decrypt_in,
    input  logic            c0_hash_in,
    output logic [CCW-1:0]  c0_bdo,
    output logic            c0_bdo_valid,
    input  logic            c0_bdo_ready,
    output logic [3:0]      c0_bdo_type,
    output logic            c0_bdo_eot,
    output logic            c0_msg_auth,
    output logic            c0_msg_auth_valid,
    input  logic            c0_msg_auth_ready,
    // client 1
    input  logic [CCSW-1:0] c1_key,
    input  logic            c1_key_valid,
    output logic            c1_key_ready,
    input  logic [CCW-1:0]  c1_bdi,
    input  logic            c1_bdi_valid,
    output logic            c1_bdi_ready,
    input  logic [3:0]      c1_bdi_type,
    input  logic            c1_bdi_eot,
    input  logic            c1_bdi_eoi,
    input  logic            c1_decrypt_in,
    input  logic            c1_hash_in,
    output logic [CCW-1:0]  c1_bdo,
    output logic            c1_bdo_valid,
    input  logic            c1_bdo_ready,
    output logic [3:0]      c1_bdo_type,
    output logic            c1_bdo_eot,
    output logic            c1_msg_auth,
    output logic            c1_msg_auth_valid,
    input  logic            c1_msg_auth_ready,
    // core side
    output logic [CCSW-1:0] k_key,
    output logic            k_key_valid,
    input  logic            k_key_ready,
    output logic [CCW-1:0]  k_bdi,
    output logic            k_bdi_valid,
    input  logic            k_bdi_ready,
    output logic [3:0]      k_bdi_type,
    output logic            k_bdi_eot,
    output logic            k_bdi_eoi,
    output logic            k_decrypt_in,
    output logic            k_hash_in,
    input  logic [CCW-1:0]  k_bdo,
    input  logic            k_bdo_valid,
    output logic            k_bdo_ready,
    input  logic [3:0]      k_bdo_type,
    input  logic            k_bdo_eot,
    input  logic            k_msg_auth,
    input  logic            k_msg_auth_valid,
    output logic            k_msg_auth_ready,
    output logic [1:0]      gnt,
    output logic            busy
);

    localparam logic [3:0] D_NONCE = 4'd1;
    localparam logic [3:0] D_TAG   = 4'd4;

    typedef enum logic [1:0] {IDLE, OWN, REL} state_t;

    state_t state, state_n;
    logic   owner, owner_n;
    logic   auth_pend, auth_pend_n;
`ifdef ASCON_ARB_RR_EN
    logic   last, last_n;
`endif

    logic req0, req1, win;
    logic own, own0, own1;
    logic tag_done, auth_hs, nonce_acc;

    assign req0 = c0_key_valid | (c0_bdi_valid & (c0_bdi_type == D_NONCE));
    assign req1 = c1_key_valid | (c1_bdi_valid & (c1_bdi_type == D_NONCE));

`ifdef ASCON_ARB_RR_EN
    assign win = (req0 & req1) ? ~last : req1;
`else
    assign win = ~req0;
`endif

    // Gating with rst keeps every client output quiet while reset is held.
    assign own  = (state == OWN) & ~rst;
    assign own0 = own & ~owner;
    assign own1 = own & owner;

    assign gnt  = {(state == OWN) & owner, (state == OWN) & ~owner};
    assign busy = (state == OWN);

    assign k_key        = own ? (owner ? c1_key : c0_key) : '0;
    assign k_key_valid  = own & (owner ? c1_key_valid : c0_key_valid);
    assign k_bdi        = own ? (owner ? c1_bdi : c0_bdi) : '0;
    assign k_bdi_valid  = own & (owner ? c1_bdi_valid : c0_bdi_valid);
    assign k_bdi_type   = own ? (owner ? c1_bdi_type : c0_bdi_type) : 4'd0;
    assign k_bdi_eot    = own & (owner ? c1_bdi_eot : c0_bdi_eot);
    assign k_bdi_eoi    = own & (owner ? c1_bdi_eoi : c0_bdi_eoi);
    assign k_decrypt_in = own & (owner ? c1_decrypt_in : c0_decrypt_in);
    assign k_hash_in    = own & (owner ? c1_hash_in : c0_hash_in);
    assign k_bdo_ready  = own & (owner ? c1_bdo_ready : c0_bdo_ready);
    assign k_msg_auth_ready = own & auth_pend & (owner ? c1_msg_auth_ready : c0_msg_auth_ready);

    assign c0_key_ready      = own0 & k_key_ready;
    assign c0_bdi_ready      = own0 & k_bdi_ready;
    assign c0_bdo            = own0 ? k_bdo : '0;
    assign c0_bdo_valid      = own0 & k_bdo_valid;
    assign c0_bdo_type       = own0 ? k_bdo_type : 4'd0;
    assign c0_bdo_eot        = own0 & k_bdo_eot;
    assign c0_msg_auth       = own0 & k_msg_auth;
    assign c0_msg_auth_valid = own0 & auth_pend & k_msg_auth_valid;

    assign c1_key_ready      = own1 & k_key_ready;
    assign c1_bdi_ready      = own1 & k_bdi_ready;
    assign c1_bdo            = own1 ? k_bdo : '0;
    assign c1_bdo_valid      = own1 & k_bdo_valid;
    assign c1_bdo_type       = own1 ? k_bdo_type : 4'd0;
    assign c1_bdo_eot        = own1 & k_bdo_eot;
    assign c1_msg_auth       = own1 & k_msg_auth;
    assign c1_msg_auth_valid = own1 & auth_pend & k_msg_auth_valid;

    // The core's msg_auth_valid is sticky, so only a handshake qualified by auth_pend counts.
    assign tag_done  = k_bdo_valid & k_bdo_ready & (k_bdo_type == D_TAG) & k_bdo_eot;
    assign auth_hs   = k_msg_auth_valid & k_msg_auth_ready;
    assign nonce_acc = k_bdi_valid & k_bdi_ready & (k_bdi_type == D_NONCE) & k_decrypt_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            auth_pend <= 1'b0;
`ifdef ASCON_ARB_RR_EN
            last      <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            auth_pend <= auth_pend_n;
`ifdef ASCON_ARB_RR_EN
            last      <= last_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        auth_pend_n = auth_pend;
`ifdef ASCON_ARB_RR_EN
        last_n      = last;
`endif
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_n = OWN;
                    owner_n = win;
                end
            end
            OWN: begin
                if (nonce_acc) auth_pend_n = 1'b1;
                if (auth_hs)   auth_pend_n = 1'b0;
                if (tag_done | auth_hs) state_n = REL;
            end
            REL: begin
                state_n     = IDLE;
                auth_pend_n = 1'b0;
`ifdef ASCON_ARB_RR_EN
                last_n      = owner;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ascon_arbiter.sv
// Directed bench for ascon_arbiter; the bench plays both clients and the core.
module tb_ascon_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c0_key, c1_key, c0_bdi, c1_bdi, c0_bdo, c1_bdo, k_key, k_bdi, k_bdo;
    logic        c0_key_valid, c0_key_ready, c0_bdi_valid, c0_bdi_ready, c0_bdi_eot, c0_bdi_eoi;
    logic        c0_decrypt_in, c0_hash_in, c0_bdo_valid, c0_bdo_ready, c0_bdo_eot;
    logic        c0_msg_auth, c0_msg_auth_valid, c0_msg_auth_ready;
    logic        c1_key_valid, c1_key_ready, c1_bdi_valid, c1_bdi_ready, c1_bdi_eot, c1_bdi_eoi;
    logic        c1_decrypt_in, c1_hash_in, c1_bdo_valid, c1_bdo_ready, c1_bdo_eot;
    logic        c1_msg_auth, c1_msg_auth_valid, c1_msg_auth_ready;
    logic [3:0]  c0_bdi_type, c1_bdi_type, c0_bdo_type, c1_bdo_type, k_bdi_type, k_bdo_type;
    logic        k_key_valid, k_key_ready, k_bdi_valid, k_bdi_ready, k_bdi_eot, k_bdi_eoi;
    logic        k_decrypt_in, k_hash_in, k_bdo_valid, k_bdo_ready, k_bdo_eot;
    logic        k_msg_auth, k_msg_auth_valid, k_msg_auth_ready;
    logic [1:0]  gnt;
    logic        busy;
    logic [1:0]  exp_first;

    int n_chk  = 0;
    int n_pass = 0;

    ascon_arbiter #(.CCW(32), .CCSW(32)) dut (
        .clk(clk), .rst(rst),
        .c0_key(c0_key), .c0_key_valid(c0_key_valid), .c0_key_ready(c0_key_ready),
        .c0_bdi(c0_bdi), .c0_bdi_valid(c0_bdi_valid), .c0_bdi_ready(c0_bdi_ready),
        .c0_bdi_type(c0_bdi_type), .c0_bdi_eot(c0_bdi_eot), .c0_bdi_eoi(c0_bdi_eoi),
        .c0_decrypt_in(c0_decrypt_in), .c0_hash_in(c0_hash_in),
        .c0_bdo(c0_bdo), .c0_bdo_valid(c0_bdo_valid), .c0_bdo_ready(c0_bdo_ready),
        .c0_bdo_type(c0_bdo_type), .c0_bdo_eot(c0_bdo_eot),
        .c0_msg_auth(c0_msg_auth), .c0_msg_auth_valid(c0_msg_auth_valid),
        .c0_msg_auth_ready(c0_msg_auth_ready),
        .c1_key(c1_key), .c1_key_valid(c1_key_valid), .c1_key_ready(c1_key_ready),
        .c1_bdi(c1_bdi), .c1_bdi_valid(c1_bdi_valid), .c1_bdi_ready(c1_bdi_ready),
        .c1_bdi_type(c1_bdi_type), .c1_bdi_eot(c1_bdi_eot), .c1_bdi_eoi(c1_bdi_eoi),
        .c1_decrypt_in(c1_decrypt_in), .c1_hash_in(c1_hash_in),
        .c1_bdo(c1_bdo), .c1_bdo_valid(c1_bdo_valid), .c1_bdo_ready(c1_bdo_ready),
        .c1_bdo_type(c1_bdo_type), .c1_bdo_eot(c1_bdo_eot),
        .c1_msg_auth(c1_msg_auth), .c1_msg_auth_valid(c1_msg_auth_valid),
        .c1_msg_auth_ready(c1_msg_auth_ready),
        .k_key(k_key), .k_key_valid(k_key_valid), .k_key_ready(k_key_ready),
        .k_bdi(k_bdi), .k_bdi_valid(k_bdi_valid), .k_bdi_ready(k_bdi_ready),
        .k_bdi_type(k_bdi_type), .k_bdi_eot(k_bdi_eot), .k_bdi_eoi(k_bdi_eoi),
        .k_decrypt_in(k_decrypt_in), .k_hash_in(k_hash_in),
        .k_bdo(k_bdo), .k_bdo_valid(k_bdo_valid), .k_bdo_ready(k_bdo_ready),
        .k_bdo_type(k_bdo_type), .k_bdo_eot(k_bdo_eot),
        .k_msg_auth(k_msg_auth), .k_msg_auth_valid(k_msg_auth_valid),
        .k_msg_auth_ready(k_msg_auth_ready),
        .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic clear_all;
        c0_key = '0; c0_key_valid = 0; c0_bdi = '0; c0_bdi_valid = 0; c0_bdi_type = 0;
        c0_bdi_eot = 0; c0_bdi_eoi = 0; c0_decrypt_in = 0; c0_hash_in = 0;
        c0_bdo_ready = 0; c0_msg_auth_ready = 0;
        c1_key = '0; c1_key_valid = 0; c1_bdi = '0; c1_bdi_valid = 0; c1_bdi_type = 0;
        c1_bdi_eot = 0; c1_bdi_eoi = 0; c1_decrypt_in = 0; c1_hash_in = 0;
        c1_bdo_ready = 0; c1_msg_auth_ready = 0;
        k_key_ready = 0; k_bdi_ready = 0; k_bdo = '0; k_bdo_valid = 0; k_bdo_type = 0;
        k_bdo_eot = 0; k_msg_auth = 0; k_msg_auth_valid = 0;
    endtask

    initial begin
        clear_all();
        rst = 1;
        c0_key = 32'hA0A0_0001; c0_key_valid = 1; k_key_ready = 1;
        step(); step();
        settle();
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_k_key_valid", {31'd0, k_key_valid}, 32'd0);
        check("rst_c0_key_ready", {31'd0, c0_key_ready}, 32'd0);
        rst = 0;
        settle();
        check("post_rst_gnt", {30'd0, gnt}, 32'd0);
        check("post_rst_k_key_valid", {31'd0, k_key_valid}, 32'd0);
        check("post_rst_c0_key_ready", {31'd0, c0_key_ready}, 32'd0);

        // client 0 encrypt: key, nonce, AD, MSG, then 4 tag beats
        step(); settle();
        check("enc_gnt", {30'd0, gnt}, 32'd1);
        check("enc_busy", {31'd0, busy}, 32'd1);
        check("enc_k_key", k_key, 32'hA0A0_0001);
        check("enc_c0_key_ready", {31'd0, c0_key_ready}, 32'd1);
        step();
        c0_key_valid = 0; c1_key_valid = 1; c1_key = 32'hB1B1_0001;
        c0_bdi_valid = 1; c0_bdi_type = 4'd1; c0_bdi = 32'h0000_00AA; k_bdi_ready = 1;
        settle();
        check("enc_k_bdi", k_bdi, 32'h0000_00AA);
        check("enc_k_bdi_type", {28'd0, k_bdi_type}, 32'd1);
        check("enc_c0_bdi_ready", {31'd0, c0_bdi_ready}, 32'd1);
        check("wait_c1_key_ready", {31'd0, c1_key_ready}, 32'd0);
        step();
        c0_bdi_type = 4'd2; c0_bdi = 32'h0000_00AD;
        step();
        c0_bdi_type = 4'd3; c0_bdi = 32'h0000_00CC; c0_bdi_eot = 1; c0_bdi_eoi = 1;
        settle();
        check("enc_k_bdi_eot", {31'd0, k_bdi_eot}, 32'd1);
        step();
        c0_bdi_valid = 0; c0_bdi_eot = 0; c0_bdi_eoi = 0;
        k_bdo_valid = 1; k_bdo = 32'h1234_5678; k_bdo_type = 4'd3; k_bdo_eot = 1;
        c0_bdo_ready = 1; k_msg_auth_valid = 1; c0_msg_auth_ready = 1;
        settle();
        check("enc_c0_bdo", c0_bdo, 32'h1234_5678);
        check("enc_c0_bdo_valid", {31'd0, c0_bdo_valid}, 32'd1);
        check("enc_k_bdo_ready", {31'd0, k_bdo_ready}, 32'd1);
        check("enc_c1_bdo_valid", {31'd0, c1_bdo_valid}, 32'd0);
        check("stale_c0_msg_auth_valid", {31'd0, c0_msg_auth_valid}, 32'd0);
        check("stale_k_msg_auth_ready", {31'd0, k_msg_auth_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            k_bdo_type = 4'd4; k_bdo = 32'h7A90_0000 + i; k_bdo_eot = (i == 3);
            settle();
            check("tag_beat_busy", {31'd0, busy}, 32'd1);
        end
        step();
        k_bdo_valid = 0; k_bdo_eot = 0; c0_bdo_ready = 0; c0_msg_auth_ready = 0;
        settle();
        check("rel_gnt", {30'd0, gnt}, 32'd0);
        check("rel_busy", {31'd0, busy}, 32'd0);
        check("rel_c1_key_ready", {31'd0, c1_key_ready}, 32'd0);
        step(); settle();
        check("idle_gnt", {30'd0, gnt}, 32'd0);

        // client 1 decrypt, core still holds a stale msg_auth_valid
        step(); settle();
        check("dec_gnt", {30'd0, gnt}, 32'd2);
        check("dec_c1_key_ready", {31'd0, c1_key_ready}, 32'd1);
        check("dec_c0_key_ready", {31'd0, c0_key_ready}, 32'd0);
        check("dec_stale_c1_auth_valid", {31'd0, c1_msg_auth_valid}, 32'd0);
        step();
        c1_key_valid = 0; c1_bdi_valid = 1; c1_bdi_type = 4'd1; c1_decrypt_in = 1;
        settle();
        check("dec_k_decrypt_in", {31'd0, k_decrypt_in}, 32'd1);
        step();
        c1_bdi_valid = 0; k_msg_auth_valid = 0;
        settle();
        check("dec_wait_auth_valid", {31'd0, c1_msg_auth_valid}, 32'd0);
        step();
        k_msg_auth_valid = 1; k_msg_auth = 1; c1_msg_auth_ready = 1;
        settle();
        check("dec_c1_msg_auth_valid", {31'd0, c1_msg_auth_valid}, 32'd1);
        check("dec_c1_msg_auth", {31'd0, c1_msg_auth}, 32'd1);
        check("dec_k_msg_auth_ready", {31'd0, k_msg_auth_ready}, 32'd1);
        check("dec_c0_msg_auth_valid", {31'd0, c0_msg_auth_valid}, 32'd0);
        step();
        c1_msg_auth_ready = 0; c1_decrypt_in = 0;
        settle();
        check("dec_rel_busy", {31'd0, busy}, 32'd0);
        step();

        // simultaneous requests from reset (last served = client 0)
        rst = 1;
        step();
        rst = 0;
        c0_key_valid = 1; c1_key_valid = 1; k_key_ready = 1;
        settle();
        check("sim_idle_c1_key_ready", {31'd0, c1_key_ready}, 32'd0);
`ifdef ASCON_ARB_RR_EN
        exp_first = 2'b10;
`else
        exp_first = 2'b01;
`endif
        step(); settle();
        check("sim_first_gnt", {30'd0, gnt}, {30'd0, exp_first});
        check("sim_c0_key_ready", {31'd0, c0_key_ready}, {31'd0, exp_first[0]});
        check("sim_c1_key_ready", {31'd0, c1_key_ready}, {31'd0, exp_first[1]});
        k_bdo_valid = 1; k_bdo_type = 4'd4; k_bdo_eot = 1; c0_bdo_ready = 1; c1_bdo_ready = 1;
        settle();
        check("sim_c0_bdo_valid", {31'd0, c0_bdo_valid}, {31'd0, exp_first[0]});
        step();
        k_bdo_valid = 0; k_bdo_eot = 0;
        settle();
        check("sim_rel_gnt", {30'd0, gnt}, 32'd0);
        step(); step(); settle();
        check("sim_second_gnt", {30'd0, gnt}, 32'd1);
        check("sim_second_c1_key_ready", {31'd0, c1_key_ready}, 32'd0);

        // reset in the middle of the message phase
        c0_key_valid = 0; c1_key_valid = 0;
        c0_bdi_valid = 1; c0_bdi_type = 4'd3; k_bdi_ready = 1;
        k_bdo_valid = 1; k_bdo_type = 4'd3;
        settle();
        check("msg_c0_bdi_ready", {31'd0, c0_bdi_ready}, 32'd1);
        rst = 1;
        settle();
        check("midrst_c0_bdi_ready", {31'd0, c0_bdi_ready}, 32'd0);
        check("midrst_k_bdi_valid", {31'd0, k_bdi_valid}, 32'd0);
        step();
        rst = 0;
        settle();
        check("abort_gnt", {30'd0, gnt}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_c0_bdi_ready", {31'd0, c0_bdi_ready}, 32'd0);
        check("abort_c0_bdo_valid", {31'd0, c0_bdo_valid}, 32'd0);
        step(); settle();
        check("no_req_gnt", {30'd0, gnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
